// File: rtl/pwm_pkg.sv
// Shared types, default constants and saturating helpers for the PWM ramp controller.
package pwm_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RAMP = 1'b1
    } pwm_state_e;

    localparam int PWM_PERIOD   = 10;
    localparam int PWM_CNT_W    = 4;
    localparam int PWM_STEP     = 2;
    localparam int PWM_RAMP_DIV = 4;
    localparam int PWM_DUTY_RST = 5;

    // a + b, clipped to max_val
    function automatic int unsigned sat_add(input int unsigned a, input int unsigned b,
                                            input int unsigned max_val);
        int unsigned sum_v;
        sum_v = a + b;
        return (sum_v > max_val) ? max_val : sum_v;
    endfunction

    // a - b, floored at zero
    function automatic int unsigned sat_sub(input int unsigned a, input int unsigned b);
        return (a < b) ? 32'd0 : (a - b);
    endfunction

endpackage

// File: rtl/pwm_period_counter.sv
// Free-running PWM period counter 0..PERIOD-1 with wrap and period-start strobes.
module pwm_period_counter
    import pwm_pkg::*;
#(
    parameter int PERIOD = PWM_PERIOD,
    parameter int CNT_W  = PWM_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    output logic [CNT_W-1:0] counter,
    output logic             wrap,
    output logic             period_start
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign wrap         = (cnt_q == CNT_W'(PERIOD - 1));
    assign period_start = (cnt_q == '0);
    assign counter      = cnt_q;

    // next count: wrap back to zero at the end of a period
    always_comb begin
        cnt_d = cnt_q;
        if (wrap) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Duty ramp controller: accepts target/inc/dec in IDLE, steps duty at period boundaries.
// Optional done_irq pulse on ramp completion when PWM_RAMP_DONE_IRQ_EN is defined.
module pwm_ramp_ctrl
    import pwm_pkg::*;
#(
    parameter int PERIOD   = PWM_PERIOD,
    parameter int CNT_W    = PWM_CNT_W,
    parameter int STEP     = PWM_STEP,
    parameter int RAMP_DIV = PWM_RAMP_DIV,
    parameter int DUTY_RST = PWM_DUTY_RST
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    input  logic [CNT_W-1:0] tgt_duty,
    input  logic             inc_pulse,
    input  logic             dec_pulse,
    output logic [CNT_W-1:0] duty_out,
    output logic             ramping,
    output logic             period_start,
    output logic             pwm
`ifdef PWM_RAMP_DONE_IRQ_EN
    ,
    output logic             done_irq
`endif
);

    localparam int DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

    pwm_state_e       state_q, state_d;
    logic [CNT_W-1:0] target_q, target_d;
    logic [CNT_W-1:0] duty_q, duty_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             done_q, done_d;

    logic [CNT_W-1:0] counter_s;
    logic             wrap_s;
    logic             accept_s;
    logic [CNT_W-1:0] req_tgt_s;
    logic [CNT_W-1:0] diff_s;
    logic [CNT_W-1:0] step_s;
    logic [CNT_W-1:0] stepped_duty_s;

    pwm_period_counter #(
        .PERIOD (PERIOD),
        .CNT_W  (CNT_W)
    ) u_cnt (
        .clk          (clk),
        .rst          (rst),
        .counter      (counter_s),
        .wrap         (wrap_s),
        .period_start (period_start)
    );

    assign pwm      = (counter_s < duty_q);
    assign duty_out = duty_q;

    // request decode: tgt_valid wins; simultaneous inc and dec cancel out
    always_comb begin
        accept_s  = 1'b0;
        req_tgt_s = target_q;
        if (tgt_valid) begin
            accept_s  = 1'b1;
            req_tgt_s = (tgt_duty > CNT_W'(PERIOD)) ? CNT_W'(PERIOD) : tgt_duty;
        end else if (inc_pulse && !dec_pulse) begin
            accept_s  = 1'b1;
            req_tgt_s = CNT_W'(sat_add(32'(target_q), 32'(STEP), 32'(PERIOD)));
        end else if (dec_pulse && !inc_pulse) begin
            accept_s  = 1'b1;
            req_tgt_s = CNT_W'(sat_sub(32'(target_q), 32'(STEP)));
        end else begin
            accept_s  = 1'b0;
            req_tgt_s = target_q;
        end
    end

    // ramp step: move by STEP but never overshoot the target
    always_comb begin
        diff_s = (target_q > duty_q) ? (target_q - duty_q) : (duty_q - target_q);
        step_s = (diff_s > CNT_W'(STEP)) ? CNT_W'(STEP) : diff_s;
        if (target_q > duty_q) begin
            stepped_duty_s = duty_q + step_s;
        end else begin
            stepped_duty_s = duty_q - step_s;
        end
    end

    // next-state logic
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        duty_d   = duty_q;
        div_d    = div_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    target_d = req_tgt_s;
                    if (req_tgt_s != duty_q) begin
                        div_d   = '0;
                        state_d = ST_RAMP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RAMP: begin
                if (wrap_s) begin
                    if (div_q == DIV_W'(RAMP_DIV - 1)) begin
                        div_d  = '0;
                        duty_d = stepped_duty_s;
                        if (stepped_duty_s == target_q) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_RAMP;
                        end
                    end else begin
                        div_d = div_q + DIV_W'(1);
                    end
                end else begin
                    div_d = div_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // state and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            target_q <= CNT_W'(DUTY_RST);
            duty_q   <= CNT_W'(DUTY_RST);
            div_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            duty_q   <= duty_d;
            div_q    <= div_d;
            done_q   <= done_d;
        end
    end

    // output decode
    always_comb begin
        tgt_ready = (state_q == ST_IDLE);
        ramping   = (state_q == ST_RAMP);
    end

`ifdef PWM_RAMP_DONE_IRQ_EN
    assign done_irq = done_q;
`else
    logic unused_done_s;
    assign unused_done_s = done_q;
`endif

endmodule
